timer_ctrl_4b: RTL and testbench

Synchronous controller that sequences a WIDTH-bit up-counter timer datapath. It holds a programmable period and prescaler and supports one-shot and periodic modes. It generates a single-cycle terminal-count pulse and a sticky interrupt that is cleared by an acknowledge handshake, with overrun detection. It sits between the register/config interface and the timer counter, and replaces direct free-running use of the ripple counter with a controlled, fully synchronous count.

---
 rtl/timer_ctrl_4b.sv | 148 ++++++++++++++
 tb/tb_timer_ctrl_4b.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_4b.sv
// rtl/timer_ctrl_4b.sv - timer controller: prescaled up-count to a period, one-shot/periodic, tc pulse, sticky irq/overrun
// Three-process FSM (IDLE/RUN/DONE) sequencing a synchronous count datapath.
module timer_ctrl_4b #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_clr_b,
  input  logic             i_cfg_we,
  input  logic [WIDTH-1:0] i_cfg_period,
  input  logic [PRE_W-1:0] i_cfg_presc,
  input  logic             i_cfg_mode,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_irq_ack,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_busy,
  output logic             o_irq,
  output logic             o_ovr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PRE_W-1:0] PSC_ONE = PRE_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_period;
  logic [PRE_W-1:0] r_presc;
  logic             r_mode;
  logic [WIDTH-1:0] r_cnt;
  logic [PRE_W-1:0] r_psc_cnt;
  logic             r_tc;
  logic             r_irq;
  logic             r_ovr;

  logic w_run;
  logic w_cfg_ok;
  logic w_launch;
  logic w_tick;
  logic w_at_tc;
  logic w_tc_set;

  assign w_run    = (r_state == ST_RUN);
  assign w_cfg_ok = i_cfg_we && !w_run;
  assign w_launch = !w_run && i_start && !i_stop;
  assign w_tick   = w_run && (r_psc_cnt == r_presc);
  assign w_at_tc  = w_tick && (r_cnt == r_period);
  // stop wins over a terminal tick landing on the same edge
  assign w_tc_set = w_at_tc && !i_stop;

  always_ff @(posedge i_clk or negedge i_clr_b) begin
    if (!i_clr_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_launch) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_at_tc && !r_mode) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_RUN);
  end

  // Config latches alongside a coincident start so the new values govern that run
  always_ff @(posedge i_clk or negedge i_clr_b) begin
    if (!i_clr_b) begin
      r_period <= '0;
      r_presc  <= '0;
      r_mode   <= 1'b0;
    end else if (w_cfg_ok) begin
      r_period <= i_cfg_period;
      r_presc  <= i_cfg_presc;
      r_mode   <= i_cfg_mode;
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_b) begin
    if (!i_clr_b) begin
      r_cnt     <= '0;
      r_psc_cnt <= '0;
    end else if (w_launch) begin
      r_cnt     <= '0;
      r_psc_cnt <= '0;
    end else if (w_run && !i_stop) begin
      r_psc_cnt <= w_tick ? '0 : (r_psc_cnt + PSC_ONE);
      if (w_tick) begin
        if (r_cnt == r_period) begin
          if (r_mode) begin
            r_cnt <= '0;
          end
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_b) begin
    if (!i_clr_b) begin
      r_tc  <= 1'b0;
      r_irq <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_tc <= w_tc_set;
      if (w_tc_set) begin
        r_irq <= 1'b1;
      end else if (i_irq_ack) begin
        r_irq <= 1'b0;
      end
      if (w_cfg_ok) begin
        r_ovr <= 1'b0;
      end else if (w_tc_set && r_irq && !i_irq_ack) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = r_tc;
  assign o_irq = r_irq;
  assign o_ovr = r_ovr;

endmodule

// File: tb/tb_timer_ctrl_4b.sv
// tb/tb_timer_ctrl_4b.sv - directed and random stimulus for timer_ctrl_4b against an elapsed-cycle reference model
module tb_timer_ctrl_4b;
  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             clr_b;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_period;
  logic [PRE_W-1:0] cfg_presc;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic             irq_ack;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;
  logic             irq;
  logic             ovr;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: count derived from edges elapsed since the start edge
  int m_period, m_presc, m_mode, m_k, m_hold;
  bit m_running, m_tc, m_irq, m_ovr;

  timer_ctrl_4b #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .i_clk(clk), .i_clr_b(clr_b), .i_cfg_we(cfg_we), .i_cfg_period(cfg_period),
    .i_cfg_presc(cfg_presc), .i_cfg_mode(cfg_mode), .i_start(start), .i_stop(stop),
    .i_irq_ack(irq_ack), .o_cnt(cnt), .o_tc(tc), .o_busy(busy), .o_irq(irq), .o_ovr(ovr)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    if (m_running) return (m_k / (m_presc + 1)) % (m_period + 1);
    return m_hold;
  endfunction

  task automatic model_reset();
    m_period = 0; m_presc = 0; m_mode = 0; m_k = 0; m_hold = 0;
    m_running = 0; m_tc = 0; m_irq = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    m_tc = 0;
    if (m_running) begin
      if (stop) begin
        m_hold    = m_count();
        m_running = 0;
      end else begin
        m_k++;
        if (m_k % ((m_period + 1) * (m_presc + 1)) == 0) begin
          m_tc = 1;
          if (m_mode == 0) begin
            m_running = 0;
            m_hold    = m_period;
          end
        end
      end
    end else begin
      if (cfg_we) begin
        m_period = int'(cfg_period);
        m_presc  = int'(cfg_presc);
        m_mode   = int'(cfg_mode);
        m_ovr    = 0;
      end
      if (start && !stop) begin
        m_running = 1;
        m_k       = 0;
      end
    end
    if (m_tc) begin
      if (m_irq && !irq_ack) m_ovr = 1;
      m_irq = 1;
    end else if (irq_ack) begin
      m_irq = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"},  32'(cnt),  32'(m_count()));
    chk({tag, ".tc"},   32'(tc),   32'(m_tc));
    chk({tag, ".busy"}, 32'(busy), 32'(m_running));
    chk({tag, ".irq"},  32'(irq),  32'(m_irq));
    chk({tag, ".ovr"},  32'(ovr),  32'(m_ovr));
  endtask

  task automatic drv(input bit we, input int p, input int s, input bit m,
                     input bit st, input bit sp, input bit ack);
    cfg_we     = we;
    cfg_period = p[WIDTH-1:0];
    cfg_presc  = s[PRE_W-1:0];
    cfg_mode   = m;
    start      = st;
    stop       = sp;
    irq_ack    = ack;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    clr_b = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("rst");
    #3 clr_b = 1'b1;

    // one-shot, period 3, presc 0
    drv(1, 3, 0, 0, 0, 0, 0); step("t1cfg");
    drv(0, 0, 0, 0, 1, 0, 0); step("t1go");
    drv(0, 0, 0, 0, 0, 0, 0); run(6, "t1run");

    // periodic, period 2, presc 2, one ack pulse after first tc
    drv(1, 2, 2, 1, 1, 0, 1); step("t2go");
    drv(0, 0, 0, 0, 0, 0, 0); run(10, "t2run");
    drv(0, 0, 0, 0, 0, 0, 1); step("t2ack");
    drv(0, 0, 0, 0, 0, 0, 0); run(20, "t2run2");

    // overrun, then ack coincident with tc, then cfg clears ovr
    drv(0, 0, 0, 0, 0, 1, 0); step("t3stop");
    drv(1, 1, 0, 1, 1, 0, 0); step("t3go");
    drv(0, 0, 0, 0, 0, 0, 0); run(6, "t3ovr");
    drv(0, 0, 0, 0, 0, 0, 1); run(4, "t3ack");
    drv(0, 0, 0, 0, 0, 1, 0); step("t3stop2");
    drv(1, 1, 0, 1, 0, 0, 0); step("t3cfg");

    // stop+start at cnt 5, cfg_we during RUN ignored
    drv(1, 9, 0, 1, 1, 0, 1); step("t4go");
    drv(1, 4, 3, 0, 0, 0, 0); run(4, "t4we");
    drv(0, 0, 0, 0, 0, 0, 0); step("t4run");
    drv(0, 0, 0, 0, 1, 1, 0); step("t4ss");
    drv(0, 0, 0, 0, 0, 0, 0); run(3, "t4idle");

    // full-range wrap, then period 0
    drv(1, 15, 0, 1, 1, 0, 0); step("t5go");
    drv(0, 0, 0, 0, 0, 0, 0); run(20, "t5wrap");
    drv(0, 0, 0, 0, 0, 1, 0); step("t5stop");
    drv(1, 0, 0, 1, 1, 0, 0); step("t5go0");
    drv(0, 0, 0, 0, 0, 0, 1); run(5, "t5p0");

    // async reset mid-count, then start with reset config
    drv(0, 0, 0, 0, 0, 1, 0); step("t6stop");
    drv(1, 7, 1, 1, 1, 0, 0); step("t6go");
    drv(0, 0, 0, 0, 0, 0, 0); run(5, "t6run");
    #2 clr_b = 1'b0;
    #1;
    model_reset();
    check_all("t6arst");
    #2 clr_b = 1'b1;
    drv(0, 0, 0, 0, 1, 0, 0); step("t6go2");
    drv(0, 0, 0, 0, 0, 0, 0); run(3, "t6done");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
